// File: rtl/cascade_mod_counter_pkg.sv
// rtl/cascade_mod_counter_pkg.sv - shared types, defaults and parameter checks for cascade_mod_counter
package cascade_mod_counter_pkg;

  localparam int unsigned DIGIT_W_DEF = 4;
  localparam int unsigned MODULUS_DEF = 10;

  typedef logic [DIGIT_W_DEF-1:0] digit_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_CLR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CNT  = 2'd3
  } op_e;

  function automatic bit modulus_ok(input int unsigned w, input int unsigned m);
    return (w >= 1) && (w <= 30) && (m >= 2) && (m <= (32'd1 << w));
  endfunction

endpackage

// File: rtl/cascade_mod_counter_digit.sv
// rtl/cascade_mod_counter_digit.sv - one modulo-MODULUS digit register (module mod_counter_digit)
module mod_counter_digit
  import cascade_mod_counter_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEF,
  parameter int unsigned MODULUS = MODULUS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] value,
  output logic               at_max,
  output logic               at_zero,
  output logic               clamp
);

  // MODULUS may equal 2**DIGIT_W, so the range compare needs one extra bit.
  localparam logic [DIGIT_W:0]   MOD_C = (DIGIT_W+1)'(MODULUS);
  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] value_q, value_d;

  assign value   = value_q;
  assign at_max  = (value_q == MAX_V);
  assign at_zero = (value_q == '0);
  assign clamp   = ({1'b0, ld_val} >= MOD_C);

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = clamp ? MAX_V : ld_val;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + DIGIT_W'(1);
    end else if (dec) begin
      value_d = at_zero ? MAX_V : value_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/cascade_mod_counter.sv
// rtl/cascade_mod_counter.sv - cascaded multi-digit modulo counter; define CNT_SATURATE_EN to saturate
// instead of wrapping at full range.
module cascade_mod_counter
  import cascade_mod_counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tc,
  output logic                      ovf,
  output logic                      load_err
);

  if (!modulus_ok(DIGIT_W, MODULUS) || (DIGITS < 1)) begin : g_bad_param
    $error("cascade_mod_counter: MODULUS must lie in 2..2**DIGIT_W and DIGITS must be >= 1");
  end

  op_e               op;
  logic              step_en;
  logic [DIGITS-1:0] at_max, at_zero, clamp, inc, dec;
  logic              ovf_q, ovf_d;
  logic              load_err_q, load_err_d;

  always_comb begin
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_CNT;
  end

  assign tc = en & (up ? (&at_max) : (&at_zero));

`ifdef CNT_SATURATE_EN
  assign step_en = (op == OP_CNT) & ~tc;
`else
  assign step_en = (op == OP_CNT);
`endif

  // Prefix-AND of lower digits, expanded per digit so every carry settles in one edge.
  always_comb begin
    logic all_max, all_zero;
    inc = '0;
    dec = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      all_max  = 1'b1;
      all_zero = 1'b1;
      for (int j = 0; j < i; j++) begin
        all_max  = all_max & at_max[j];
        all_zero = all_zero & at_zero[j];
      end
      inc[i] = step_en & up & all_max;
      dec[i] = step_en & ~up & all_zero;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    mod_counter_digit #(
      .DIGIT_W (DIGIT_W),
      .MODULUS (MODULUS)
    ) u_digit (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[g]),
      .dec     (dec[g]),
      .clr     (op == OP_CLR),
      .load    (op == OP_LOAD),
      .ld_val  (load_val[g*DIGIT_W +: DIGIT_W]),
      .value   (count[g*DIGIT_W +: DIGIT_W]),
      .at_max  (at_max[g]),
      .at_zero (at_zero[g]),
      .clamp   (clamp[g])
    );
  end

  always_comb begin
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    case (op)
      OP_CLR:  ovf_d = 1'b0;
      OP_LOAD: load_err_d = |clamp;
      OP_CNT:  if (tc) ovf_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule
